// File: rtl/key_expander.sv
// AES key-expansion engine for 128/192/256-bit keys: one schedule word per cycle,
// round keys streamed out as 128-bit beats under a valid/ready handshake.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] q
);
    // Row r holds S(16r) .. S(16r+15), most significant byte first.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign q = SBOX[(255 - int'(a)) * 8 +: 8];
endmodule

module sub_word (
    input  logic [31:0] w,
    output logic [31:0] s
);
    for (genvar b = 0; b < 4; b++) begin : g_lane
        aes_sbox u_sbox (.a(w[8*b +: 8]), .q(s[8*b +: 8]));
    end
endmodule

module rot_word (
    input  logic [31:0] w,
    output logic [31:0] r
);
    // Byte 0 lives in [7:0], so [a0,a1,a2,a3] -> [a1,a2,a3,a0] is a right rotate.
    assign r = {w[7:0], w[31:8]};
endmodule

module key_expander #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                busy,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [127:0]        rk_data,
    output logic [3:0]          rk_index,
    output logic                done
);
    localparam int NK   = KEY_BITS / 32;
    localparam int NR   = NK + 6;
    localparam int NTOT = 4 * (NR + 1);
    localparam logic IS256 = (NK == 8);

    if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key
        $error("key_expander: KEY_BITS must be 128, 192 or 256");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;

    // win holds w[i-NK] .. w[i-1], oldest in slot 0.
    logic [NK-1:0][31:0] win;
    logic [3:0][31:0]    rk_buf;
    logic [5:0]          wcnt;
    logic [2:0]          kpos;
    logic [7:0]          rcon;
    logic                rk_valid_q;
    logic [3:0]          rk_index_q;

    logic        hs, we;
    logic [31:0] w_prev, w_old, w_rot, sw_in, w_sub, t, w_new;

    assign hs     = rk_valid_q && rk_ready;
    assign we     = (state == RUN) && (wcnt < 6'(NTOT)) && (!rk_valid_q || rk_ready);
    assign w_prev = win[NK-1];
    assign w_old  = win[0];
    assign sw_in  = (kpos == 3'd0) ? w_rot : w_prev;

    rot_word u_rot (.w(w_prev), .r(w_rot));
    sub_word u_sub (.w(sw_in),  .s(w_sub));

    always_comb begin
        t = w_prev;
        if (kpos == 3'd0)
            t = w_sub ^ {24'h0, rcon};
        else if (IS256 && kpos == 3'd4)
            t = w_sub;
    end

    // The first NK cycles just rotate the latched key through the window.
    assign w_new = (wcnt < 6'(NK)) ? w_old : (w_old ^ t);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (hs && rk_index_q == 4'(NR)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            win        <= '0;
            rk_buf     <= '0;
            wcnt       <= '0;
            kpos       <= '0;
            rcon       <= '0;
            rk_valid_q <= 1'b0;
            rk_index_q <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                win        <= key_in;
                rk_buf     <= '0;
                wcnt       <= '0;
                kpos       <= '0;
                rcon       <= 8'h01;
                rk_valid_q <= 1'b0;
                rk_index_q <= '0;
            end else if (state == RUN) begin
                if (hs) begin
                    rk_buf     <= '0;
                    rk_valid_q <= 1'b0;
                end
                if (we) begin
                    win                  <= {w_new, win[NK-1:1]};
                    rk_buf[wcnt[1:0]]    <= w_new;
                    wcnt                 <= wcnt + 6'd1;
                    kpos                 <= (kpos == 3'(NK-1)) ? 3'd0 : kpos + 3'd1;
                    if (wcnt >= 6'(NK) && kpos == 3'd0)
                        rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                    if (wcnt[1:0] == 2'd3) begin
                        rk_valid_q <= 1'b1;
                        rk_index_q <= wcnt[5:2];
                    end
                end
            end
        end
    end

    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign rk_valid = rk_valid_q;
    assign rk_data  = rk_buf;
    assign rk_index = rk_index_q;
endmodule

// File: doc/key_expander.md
Name: key_expander

Overview:
- Sequential AES key-expansion engine, parametrised for 128/192/256-bit keys.
- Accepts a cipher key on a `start` pulse and emits round keys 0..Nr as a 128-bit stream under a valid/ready handshake.
- Generates one 32-bit schedule word per cycle and reuses the existing `rot_word` and `sub_word` blocks.
- Feeds round-key consumers: cipher round datapath or round-key RAM loader.

Parameters:
- KEY_BITS, 128, cipher key length; legal values 128, 192, 256; any other value is an elaboration error. Derived: Nk = KEY_BITS/32 (4/6/8), Nr = Nk+6 (10/12/14), Ntot = 4*(Nr+1) words (44/52/60).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin expansion; sampled only when busy=0.
- key_in  in  KEY_BITS  cipher key; word i at [32i+31:32i]; byte 0 of each word at [7:0].
- busy  out  1  expansion in progress.
- rk_valid  out  1  rk_data holds a complete round key.
- rk_ready  in  1  consumer accepts the round key.
- rk_data  out  128  round key; word 0 at [31:0], word 3 at [127:96].
- rk_index  out  4  round number (0..Nr) of rk_data.
- done  out  1  one-cycle pulse after the final round key is accepted.

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-low (clk, rst_n). Reset applies at any time, including mid-expansion: busy, rk_valid and done go to 0; rk_data, rk_index, the word counter and the rcon register go to 0; FSM returns to IDLE. Partial results are discarded.
- States:
  - IDLE: start=1 at edge E0 latches key_in into an Nk-word window register, clears the word counter i and the 4-word output buffer, sets rcon=0x01, sets busy=1, and moves to RUN. start is ignored while busy=1.
  - RUN: each cycle the producer may write word w[i] into output-buffer slot i mod 4.
    - i < Nk: w[i] is key word i.
    - i >= Nk: w[i] = w[i-Nk] XOR t, with t defined as follows:
      - i mod Nk = 0: t = sub_word(rot_word(w[i-1])) XOR {24'h0, rcon}; rcon then advances by xtime (doubling; 0x80 becomes 0x1b).
      - Nk = 8 and i mod 8 = 4: t = sub_word(w[i-1]).
      - otherwise: t = w[i-1].
    - Generated words shift into the window (oldest out).
  - Producer stall: the producer stalls when the buffer holds 4 words and rk_valid=1 && rk_ready=0.
  - Handshake: a handshake (rk_valid && rk_ready) clears the buffer; the producer may write the next word on the same edge.
  - rk_valid: asserted after the edge that writes the 4th word. rk_data and rk_index are stable while rk_valid=1 && rk_ready=0.
  - Final beat: on the handshake of rk_index = Nr, go to DONE.
  - DONE: one cycle; done=1, busy=0, rk_valid=0; then IDLE.
- Latency with rk_ready held at 1:
  - word j is written at edge E(j+1);
  - round key k becomes valid after edge E(4k+4) and is accepted at E(4k+5);
  - throughput is 1 word/cycle;
  - the final handshake is at E(4Nr+5), i.e. E45, E53 or E61 for 128, 192, 256;
  - done is high in the cycle after that handshake.
- rk_ready is don't-care while rk_valid=0. With rk_ready low, the engine holds indefinitely and no words are lost or duplicated.
- A start asserted in the DONE cycle is ignored. A start in IDLE on the cycle after DONE is accepted.

Test Plan:
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c (FIPS-197 A.1 byte order), rk_ready=1 -> rk_index 0 equals the key; rk_index 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 accepted at E45; done pulses once; exactly 11 handshakes.
- KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> 13 round keys; w[51] = 01002202; final handshake at E53.
- KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> 15 round keys; w[59] = 706c631e; the i mod 8 = 4 sub_word path is exercised; final handshake at E61.
- Random rk_ready backpressure (including a 20-cycle stall on round 3), 128-bit vector -> identical round-key sequence to the no-stall run; rk_data and rk_index stable throughout each stall.
- start pulsed mid-expansion, then rst_n=0 for 1 cycle at round 5 -> mid-expansion start ignored; after reset all outputs are 0 and state is IDLE; a new start reproduces a correct full expansion from rk_index 0.
- Back-to-back: start asserted in the DONE cycle, then again the next cycle -> first start ignored; second start accepted; second expansion correct.
